// File: rtl/scie_cfir_pipelined_if.sv
// Custom-instruction bus for the SCIE complex FIR unit.
// Core side drives instructions; unit returns ready and READ results.
interface scie_cfir_pipelined_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
);
    logic                     io_valid;
    logic                     io_ready;
    logic [31:0]              io_insn;
    logic signed [DATA_W-1:0] io_rs1_real;
    logic signed [DATA_W-1:0] io_rs1_imag;
    logic [31:0]              io_rs2;
    logic signed [OUT_W-1:0]  io_rd_real;
    logic signed [OUT_W-1:0]  io_rd_imag;
    logic                     io_rd_valid;

    modport master (
        output io_valid, io_insn, io_rs1_real, io_rs1_imag, io_rs2,
        input  io_ready, io_rd_real, io_rd_imag, io_rd_valid
    );

    modport slave (
        input  io_valid, io_insn, io_rs1_real, io_rs1_imag, io_rs2,
        output io_ready, io_rd_real, io_rd_imag, io_rd_valid
    );
endinterface

// File: rtl/scie_cfir_pipelined.sv
// Time-multiplexed complex FIR custom-instruction unit.
// Define SCIE_CFIR_SAT_EN to saturate results instead of wrapping.
module scie_cfir_pipelined #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 5,
    parameter int LANES  = 1,
    parameter int OUT_W  = 32
) (
    input logic             clock,
    input logic             reset,
    scie_cfir_pipelined_if.slave cpu
);
    localparam int ACC_W = 2*DATA_W + 1 + $clog2(TAPS);
    localparam int N     = (TAPS + LANES - 1) / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = $clog2(TAPS + LANES) + 1;

    localparam logic [6:0] OP_LOAD  = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;
    localparam logic [6:0] OP_CLEAR = 7'h7B;

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_MAC
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] coef_re [TAPS];
    logic signed [DATA_W-1:0] coef_im [TAPS];
    logic signed [DATA_W-1:0] x_re [TAPS];
    logic signed [DATA_W-1:0] x_im [TAPS];

    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic signed [ACC_W-1:0] acc_re_nxt, acc_im_nxt;
    logic signed [OUT_W-1:0] res_re, res_im;
    logic [CNT_W-1:0]        cnt;
    logic                    last;

    logic       accept;
    logic [6:0] op;
    logic       is_load, is_push, is_read, is_clear;
    logic       unused_insn;

`ifdef SCIE_CFIR_SAT_EN
    localparam int MW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [MW-1:0] SMAX =
        {{(MW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [MW-1:0] SMIN =
        {{(MW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] narrow(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [MW-1:0] e;
        e = MW'(v);
        if (e > SMAX)      return SMAX[OUT_W-1:0];
        else if (e < SMIN) return SMIN[OUT_W-1:0];
        else               return e[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] narrow(
        input logic signed [ACC_W-1:0] v
    );
        return OUT_W'(v);
    endfunction
`endif

    assign cpu.io_ready = (state == S_IDLE);
    assign accept       = cpu.io_valid & cpu.io_ready;
    assign op           = cpu.io_insn[6:0];
    assign unused_insn  = ^cpu.io_insn[31:7];

    assign is_load  = accept && (op == OP_LOAD);
    assign is_push  = accept && (op == OP_PUSH);
    assign is_read  = accept && (op == OP_READ);
    assign is_clear = accept && (op == OP_CLEAR);

    assign last = (cnt == CNT_W'(N-1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT: state_nxt = S_IDLE;
            S_IDLE: if (is_push) state_nxt = S_MAC;
            S_MAC:  if (last) state_nxt = S_IDLE;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Each lane picks tap base+l through a mux; out-of-range lanes stay 0.
    always_comb begin
        logic [IDX_W-1:0]         base;
        logic signed [DATA_W-1:0] cr, ci, xr, xi;
        logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
        sum_re = '0;
        sum_im = '0;
        cr = '0; ci = '0; xr = '0; xi = '0;
        p_rr = '0; p_ii = '0; p_ri = '0; p_ir = '0;
        base = IDX_W'(cnt) * IDX_W'(LANES);
        for (int l = 0; l < LANES; l++) begin
            cr = '0; ci = '0; xr = '0; xi = '0;
            for (int t = 0; t < TAPS; t++) begin
                if (IDX_W'(t) == base + IDX_W'(l)) begin
                    cr = coef_re[t];
                    ci = coef_im[t];
                    xr = x_re[t];
                    xi = x_im[t];
                end
            end
            p_rr = cr * xr;
            p_ii = ci * xi;
            p_ri = cr * xi;
            p_ir = ci * xr;
            sum_re = sum_re + ACC_W'(p_rr) - ACC_W'(p_ii);
            sum_im = sum_im + ACC_W'(p_ri) + ACC_W'(p_ir);
        end
    end

    assign acc_re_nxt = acc_re + sum_re;
    assign acc_im_nxt = acc_im + sum_im;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_re[k] <= '0;
                coef_im[k] <= '0;
                x_re[k]    <= '0;
                x_im[k]    <= '0;
            end
            acc_re          <= '0;
            acc_im          <= '0;
            res_re          <= '0;
            res_im          <= '0;
            cnt             <= '0;
            cpu.io_rd_real  <= '0;
            cpu.io_rd_imag  <= '0;
            cpu.io_rd_valid <= 1'b0;
        end else begin
            cpu.io_rd_valid <= 1'b0;
            if (state == S_MAC) begin
                if (last) begin
                    res_re <= narrow(acc_re_nxt);
                    res_im <= narrow(acc_im_nxt);
                    acc_re <= '0;
                    acc_im <= '0;
                    cnt    <= '0;
                end else begin
                    acc_re <= acc_re_nxt;
                    acc_im <= acc_im_nxt;
                    cnt    <= cnt + 1'b1;
                end
            end
            unique case (1'b1)
                is_load: begin
                    for (int k = 0; k < TAPS; k++) begin
                        if (cpu.io_rs2 == 32'(k)) begin
                            coef_re[k] <= cpu.io_rs1_real;
                            coef_im[k] <= cpu.io_rs1_imag;
                        end
                    end
                end
                is_push: begin
                    for (int k = TAPS-1; k > 0; k--) begin
                        x_re[k] <= x_re[k-1];
                        x_im[k] <= x_im[k-1];
                    end
                    x_re[0] <= cpu.io_rs1_real;
                    x_im[0] <= cpu.io_rs1_imag;
                    cnt     <= '0;
                end
                is_read: begin
                    cpu.io_rd_real  <= res_re;
                    cpu.io_rd_imag  <= res_im;
                    cpu.io_rd_valid <= 1'b1;
                end
                is_clear: begin
                    for (int k = 0; k < TAPS; k++) begin
                        x_re[k] <= '0;
                        x_im[k] <= '0;
                    end
                    res_re         <= '0;
                    res_im         <= '0;
                    cpu.io_rd_real <= '0;
                    cpu.io_rd_imag <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
